fp_to_int: RTL

FP_TO_INT -- requirements
Module: fp_to_int

---
 rtl/fp_to_int.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp_to_int.sv
// IEEE-754 single-precision to 32-bit signed integer converter, truncating toward zero.
// Normal operands are aligned one bit per cycle; out-of-range classes saturate.
module fp_to_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sign_q, sign_d;
    logic        special_q, special_d;
    logic        spec_ovf_q, spec_ovf_d;
    logic        sticky_q, sticky_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        inexact_q, inexact_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  x;
    logic [22:0] frac;

    assign x    = a[30:23];
    assign frac = a[22:0];

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        sign_d      = sign_q;
        special_d   = special_q;
        spec_ovf_d  = spec_ovf_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        inexact_d   = inexact_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = SHIFT;
                    sign_d     = a[31];
                    left_d     = 1'b0;
                    cnt_d      = 5'd0;
                    sticky_d   = 1'b0;
                    special_d  = 1'b1;
                    spec_ovf_d = 1'b1;
                    // Special classes park their final value in the working register
                    if (x < 8'd127) begin
                        work_d     = 32'h0000_0000;
                        spec_ovf_d = 1'b0;
                        sticky_d   = |a[30:0];
                    end else if (x == 8'd255 && frac != 23'd0) begin
                        work_d = 32'h7FFF_FFFF;
                    end else if (x >= 8'd158) begin
                        if (a[31]) begin
                            work_d     = 32'h8000_0000;
                            spec_ovf_d = (a != 32'hCF00_0000);
                        end else begin
                            work_d = 32'h7FFF_FFFF;
                        end
                    end else begin
                        special_d  = 1'b0;
                        spec_ovf_d = 1'b0;
                        work_d     = {8'd0, 1'b1, frac};
                        if (x >= 8'd150) begin
                            left_d = 1'b1;
                            cnt_d  = 5'(x - 8'd150);
                        end else begin
                            cnt_d  = 5'(8'd150 - x);
                        end
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd0) begin
                    if (special_q || !sign_q) result_d = work_q;
                    else                      result_d = ~work_q + 32'd1;
                    overflow_d  = special_q & spec_ovf_q;
                    inexact_d   = sticky_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    if (left_q) begin
                        work_d = {work_q[30:0], 1'b0};
                    end else begin
                        work_d   = {1'b0, work_q[31:1]};
                        sticky_d = sticky_q | work_q[0];
                    end
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= 32'd0;
            cnt_q       <= 5'd0;
            left_q      <= 1'b0;
            sign_q      <= 1'b0;
            special_q   <= 1'b0;
            spec_ovf_q  <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sign_q      <= sign_d;
            special_q   <= special_d;
            spec_ovf_q  <= spec_ovf_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign inexact   = inexact_q;

endmodule
